// File: rtl/load_use_scoreboard.sv
// Issue-stage load-use hazard scoreboard: grants the longest hazard-free in-order prefix of an issue group.
// Optional feature macro: HAZARD_STALL_CNT_EN adds the saturating 32-bit stall_cycles counter output.
module load_use_scoreboard #(
    parameter int ISSUE_W  = 2,
    parameter int NREG     = 32,
    parameter int REGW     = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic                    clk1,
    input  logic                    reset,
    input  logic [ISSUE_W-1:0]      iss_valid,
    input  logic [ISSUE_W*REGW-1:0] iss_rs1,
    input  logic [ISSUE_W*REGW-1:0] iss_rs2,
    input  logic [ISSUE_W-1:0]      iss_rs1_en,
    input  logic [ISSUE_W-1:0]      iss_rs2_en,
    input  logic [ISSUE_W*REGW-1:0] iss_rd,
    input  logic [ISSUE_W-1:0]      iss_wr_en,
    input  logic [ISSUE_W-1:0]      iss_is_load,
    input  logic                    flush,
    input  logic                    pipe_hold,
    output logic [ISSUE_W-1:0]      iss_grant,
    output logic                    stall,
    output logic [NREG-1:0]         busy_mask
`ifdef HAZARD_STALL_CNT_EN
    , output logic [31:0]           stall_cycles
`endif
);

    localparam int CW = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);

    logic [ISSUE_W-1:0] hazard_free;

    // Indices beyond NREG can never be pending.
    function automatic logic is_busy(input logic [REGW-1:0] idx, input logic [NREG-1:0] mask);
        if (int'(idx) < NREG) begin
            return mask[idx];
        end
        return 1'b0;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < ISSUE_W; gi++) begin : g_slot
            logic [REGW-1:0] rs1;
            logic [REGW-1:0] rs2;
            logic [REGW-1:0] rd;
            logic            pend_haz;
            logic            grp_haz;

            assign rs1 = iss_rs1[gi*REGW +: REGW];
            assign rs2 = iss_rs2[gi*REGW +: REGW];
            assign rd  = iss_rd[gi*REGW +: REGW];

            assign pend_haz = (iss_rs1_en[gi] && is_busy(rs1, busy_mask))
                           || (iss_rs2_en[gi] && is_busy(rs2, busy_mask))
                           || (iss_wr_en[gi]  && is_busy(rd,  busy_mask));

            // Any earlier valid writer in the group blocks a read or rewrite of its rd.
            always_comb begin
                grp_haz = 1'b0;
                for (int j = 0; j < gi; j++) begin
                    if (iss_valid[j] && iss_wr_en[j]) begin
                        if ((iss_rs1_en[gi] && rs1 == iss_rd[j*REGW +: REGW])
                         || (iss_rs2_en[gi] && rs2 == iss_rd[j*REGW +: REGW])
                         || (iss_wr_en[gi]  && rd  == iss_rd[j*REGW +: REGW])) begin
                            grp_haz = 1'b1;
                        end
                    end
                end
            end

            assign hazard_free[gi] = !pend_haz && !grp_haz;
        end
    endgenerate

    // First blocked slot ends the grant prefix.
    always_comb begin
        logic ok;
        iss_grant = '0;
        ok = !flush && !pipe_hold;
        for (int k = 0; k < ISSUE_W; k++) begin
            ok = ok && iss_valid[k] && hazard_free[k];
            iss_grant[k] = ok;
        end
    end

    assign stall = (|(iss_valid & ~iss_grant)) && !flush;

    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;
            logic          load_set;

            always_comb begin
                load_set = 1'b0;
                for (int k = 0; k < ISSUE_W; k++) begin
                    if (iss_grant[k] && iss_is_load[k] && iss_wr_en[k]
                        && int'(iss_rd[k*REGW +: REGW]) == gi) begin
                        load_set = 1'b1;
                    end
                end
            end

            always_comb begin
                cnt_next = cnt_reg;
                if (flush) begin
                    cnt_next = '0;
                end else if (!pipe_hold) begin
                    if (load_set) begin
                        cnt_next = CW'(LOAD_LAT);
                    end else if (cnt_reg != '0) begin
                        cnt_next = cnt_reg - CW'(1);
                    end
                end
            end

            always_ff @(posedge clk1 or posedge reset) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign busy_mask[gi] = (cnt_reg != '0);
        end
    endgenerate

`ifdef HAZARD_STALL_CNT_EN
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall && !pipe_hold && stall_cycles != 32'hFFFF_FFFF) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule
